// File: rtl/cpu_pkg.sv
// Shared types and default widths for the MIPS core pipeline.
package cpu_pkg;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  typedef enum logic [2:0] {
    LD_NONE = 3'd0,
    LD_W    = 3'd1,
    LD_B    = 3'd2,
    LD_BU   = 3'd3,
    LD_H    = 3'd4,
    LD_HU   = 3'd5,
    LD_LWL  = 3'd6,
    LD_LWR  = 3'd7
  } ld_type_e;

  typedef enum logic [1:0] {
    WB_IDLE = 2'd0,
    WB_LIVE = 2'd1,
    WB_HOLD = 2'd2
  } wb_state_e;

endpackage

// File: rtl/ld_align.sv
// Combinational little-endian load aligner: lane select, sign/zero extension and LWL/LWR merge.
module ld_align import cpu_pkg::*; (
  input  ld_type_e    ld_type,
  input  logic [1:0]  addr,
  input  logic [31:0] mem,
  input  logic [31:0] rt,
  output logic [31:0] aligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = mem[7:0];
    case (addr)
      2'd1:    byte_sel = mem[15:8];
      2'd2:    byte_sel = mem[23:16];
      2'd3:    byte_sel = mem[31:24];
      default: byte_sel = mem[7:0];
    endcase
    half_sel = addr[1] ? mem[31:16] : mem[15:0];

    aligned = mem;
    case (ld_type)
      LD_B:  aligned = {{24{byte_sel[7]}}, byte_sel};
      LD_BU: aligned = {24'd0, byte_sel};
      LD_H:  aligned = {{16{half_sel[15]}}, half_sel};
      LD_HU: aligned = {16'd0, half_sel};
      LD_LWL: begin
        case (addr)
          2'd0:    aligned = {mem[7:0],  rt[23:0]};
          2'd1:    aligned = {mem[15:0], rt[15:0]};
          2'd2:    aligned = {mem[23:0], rt[7:0]};
          default: aligned = mem;
        endcase
      end
      LD_LWR: begin
        case (addr)
          2'd1:    aligned = {rt[31:24], mem[31:8]};
          2'd2:    aligned = {rt[31:16], mem[31:16]};
          2'd3:    aligned = {rt[31:8],  mem[31:24]};
          default: aligned = mem;
        endcase
      end
      default: aligned = mem;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// MIPS write-back stage: one-deep holding register, load alignment, regfile write and bypass.
// Optional golden-trace outputs are enabled with `define WB_TRACE_EN.
module wb_stage import cpu_pkg::*; #(
  parameter int unsigned DW = cpu_pkg::DW,
  parameter int unsigned AW = cpu_pkg::AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ms_to_ws_valid,
  output logic          ws_allowin,
  input  logic [31:0]   ms_pc,
  input  logic          ms_rf_we,
  input  logic [AW-1:0] ms_rf_waddr,
  input  logic [DW-1:0] ms_alu_res,
  input  ld_type_e      ms_ld_type,
  input  logic [DW-1:0] ms_rt_val,
  input  logic [DW-1:0] data_sram_rdata,
  input  logic          ws_stall,
  input  logic          ws_flush,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic          fwd_valid,
  output logic [AW-1:0] fwd_addr,
  output logic [DW-1:0] fwd_data
`ifdef WB_TRACE_EN
  ,
  output logic [31:0]   debug_wb_pc,
  output logic [3:0]    debug_wb_rf_wen,
  output logic [4:0]    debug_wb_rf_wnum,
  output logic [31:0]   debug_wb_rf_wdata
`endif
);

  wb_state_e     state;
  logic          rf_we_q;
  logic [AW-1:0] waddr_q;
  logic [DW-1:0] alu_res_q;
  logic [DW-1:0] rt_val_q;
  logic [DW-1:0] rdata_q;
  ld_type_e      ld_type_q;
`ifdef WB_TRACE_EN
  logic [31:0]   pc_q;
`endif

  logic          held;
  logic          capture;
  logic          waddr_nz;
  logic [DW-1:0] rdata;
  logic [DW-1:0] aligned;

  assign held       = (state != WB_IDLE);
  assign ws_allowin = (state == WB_IDLE) || !ws_stall;
  assign capture    = ms_to_ws_valid && ws_allowin && !ws_flush;
  assign waddr_nz   = (waddr_q != '0);

  // Flush wins over capture; a stalled LIVE instruction snapshots the bus before it moves on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= WB_IDLE;
      rf_we_q   <= 1'b0;
      waddr_q   <= '0;
      alu_res_q <= '0;
      rt_val_q  <= '0;
      rdata_q   <= '0;
      ld_type_q <= LD_NONE;
`ifdef WB_TRACE_EN
      pc_q      <= '0;
`endif
    end else if (ws_flush) begin
      state <= WB_IDLE;
    end else if (capture) begin
      state     <= WB_LIVE;
      rf_we_q   <= ms_rf_we;
      waddr_q   <= ms_rf_waddr;
      alu_res_q <= ms_alu_res;
      rt_val_q  <= ms_rt_val;
      ld_type_q <= ms_ld_type;
`ifdef WB_TRACE_EN
      pc_q      <= ms_pc;
`endif
    end else if (held && !ws_stall) begin
      state <= WB_IDLE;
    end else if (state == WB_LIVE) begin
      rdata_q <= data_sram_rdata;
      state   <= WB_HOLD;
    end
  end

  assign rdata = (state == WB_HOLD) ? rdata_q : data_sram_rdata;

  ld_align u_ld_align (
    .ld_type (ld_type_q),
    .addr    (alu_res_q[1:0]),
    .mem     (rdata),
    .rt      (rt_val_q),
    .aligned (aligned)
  );

  // Write fires on the same edge the instruction leaves, so it can happen only once.
  assign rf_we     = held && !ws_stall && !ws_flush && rf_we_q && waddr_nz;
  assign rf_waddr  = waddr_q;
  assign rf_wdata  = (ld_type_q == LD_NONE) ? alu_res_q : aligned;

  assign fwd_valid = held && rf_we_q && waddr_nz;
  assign fwd_addr  = waddr_q;
  assign fwd_data  = rf_wdata;

`ifdef WB_TRACE_EN
  assign debug_wb_pc       = pc_q;
  assign debug_wb_rf_wen   = rf_we ? 4'hF : 4'h0;
  assign debug_wb_rf_wnum  = 5'(waddr_q);
  assign debug_wb_rf_wdata = 32'(rf_wdata);
`else
  logic unused_pc;
  assign unused_pc = ^ms_pc;
`endif

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Final pipeline stage of the MIPS core.
- Accepts one instruction at a time from the MEM stage over a valid/allowin handshake.
- Aligns and extends load data returned by the data SRAM.
- Produces the single register-file write port (we/waddr/wdata) and the matching bypass values for the decode stage.
- Holds SRAM read data locally whenever the stage is stalled, so the result is not lost when the bus changes.

Parameters:
- DW, 32, data/register width
- AW, 5, register address width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- ms_to_ws_valid  in  1  MEM presents an instruction
- ws_allowin  out  1  WB can accept this cycle
- ms_pc  in  32  instruction PC
- ms_rf_we  in  1  instruction writes a GPR
- ms_rf_waddr  in  AW  destination GPR
- ms_alu_res  in  DW  ALU result / effective address
- ms_ld_type  in  3  load kind (package enum)
- ms_rt_val  in  DW  old rt value for LWL/LWR merge
- data_sram_rdata  in  DW  SRAM read data, valid in the first WB cycle of a load
- ws_stall  in  1  external hold (exception commit / debug)
- ws_flush  in  1  kill the held instruction
- rf_we  out  1  regfile write enable
- rf_waddr  out  AW  regfile write address
- rf_wdata  out  DW  regfile write data
- fwd_valid  out  1  bypass entry valid
- fwd_addr  out  AW  bypass address
- fwd_data  out  DW  bypass data

Behaviour:
- Reset: asynchronous on rst=1. Forces state=IDLE and clears all payload registers. While reset is asserted, rf_we=0, fwd_valid=0 and ws_allowin=1.
- State machine:
  - IDLE: no instruction held.
  - LIVE: instruction held; load data is taken directly from data_sram_rdata.
  - HOLD: instruction held; load data comes from the internal rdata_q register.
- ws_allowin = (state==IDLE) || !ws_stall.
- Capture: on a clock edge with ms_to_ws_valid && ws_allowin, latch the payload and go to LIVE.
- Complete: if the stage holds an instruction and !ws_stall and no new instruction is captured, go to IDLE.
- Stall: LIVE with ws_stall=1 latches data_sram_rdata into rdata_q and goes to HOLD. HOLD stays in HOLD while ws_stall=1.
- Flush: ws_flush=1 forces IDLE on the next edge and overrides any capture in the same cycle. In the flush cycle rf_we=0, so no write ever occurs for a flushed instruction.
- Commit: rf_we = held && !ws_stall && !ws_flush && ms_rf_we_q && (rf_waddr_q != 0).
  - rf_we is combinational, so the regfile writes on the same edge the instruction leaves.
  - Exactly one write pulse per instruction.
- fwd_valid = held && rf_we_q && (waddr != 0), including during a stall. fwd_data = rf_wdata.
- Data select:
  - LD_NONE: alu_res.
  - LD_W: rdata.
  - Byte/half loads use lane addr = alu_res_q[1:0], little-endian.
    - LD_B / LD_BU: byte at lane, sign-extended / zero-extended.
    - LD_H / LD_HU: half at addr[1], sign-extended / zero-extended.
  - LD_LWL by addr:
    - 0: {m[7:0], rt[23:0]}
    - 1: {m[15:0], rt[15:0]}
    - 2: {m[23:0], rt[7:0]}
    - 3: m
  - LD_LWR by addr:
    - 0: m
    - 1: {rt[31:24], m[31:8]}
    - 2: {rt[31:16], m[31:16]}
    - 3: {rt[31:8], m[31:24]}
- Unaligned LD_H/LD_W addresses never reach WB (trapped in MEM); the result for them is don't-care.
- Back-to-back: with ws_stall=0, one instruction per cycle. LIVE→LIVE is valid on a simultaneous complete and capture.

Optional Feature:
- Macro: WB_TRACE_EN.
- Defined: adds outputs debug_wb_pc[31:0], debug_wb_rf_wen[3:0] (4'hF when rf_we, else 0), debug_wb_rf_wnum[4:0] and debug_wb_rf_wdata[31:0], all aligned with the rf_we cycle, for golden-trace comparison.
- Not defined: these ports and their logic are absent; the pc register is removed as well.

Decomposition:
- Package cpu_pkg:
  - LD_* enum (NONE=0, W=1, B=2, BU=3, H=4, HU=5, LWL=6, LWR=7).
  - WB state encoding (IDLE/LIVE/HOLD).
  - DW/AW defaults.
- Sub-module ld_align: purely combinational. Inputs ld_type, addr[1:0], mem data, rt value; output aligned word. It is reused by the exception/test harness.

Test Plan:
- ALU write: valid, waddr=8, alu_res=0x1234_5678, LD_NONE, no stall → rf_we=1 for exactly 1 cycle, rf_wdata=0x12345678; ws_allowin stays 1.
- LB sign: alu_res=...01, rdata=0x0000_8000, LD_B → wdata=0xFFFF_FF80. Same stimulus with LD_BU → 0x0000_0080.
- Stall hold: LD_W load with rdata=0xDEAD_BEEF. ws_stall=1 for 3 cycles while the bus changes to 0 → rf_we=0 and fwd_data=0xDEADBEEF throughout. Releasing the stall gives one write of 0xDEADBEEF.
- LWL/LWR: rt=0x1122_3344, mem=0xAABB_CCDD, addr=1.
  - LWL → 0xCCDD_3344.
  - LWR → 0x11AA_BBCC.
- $0 and flush:
  - waddr=0 → rf_we=0 and fwd_valid=0.
  - ws_flush together with a stall → no write; next cycle IDLE.
- Async reset mid-HOLD: assert rst between clock edges → rf_we and fwd_valid drop immediately. After release, the first new instruction commits normally.
